// File: rtl/bb_erisim_hakemi.sv
// bb_erisim_hakemi: arbitrates the BB port between fetch and loader with a starvation guard.
// Define YUKLE_KILIT_EN to let the loader hold exclusive ownership through yukle_kilit_g.
module bb_erisim_hakemi #(
  parameter int ADRES_BIT    = 32,
  parameter int VERI_BIT     = 32,
  parameter int ACLIK_SINIRI = 8
) (
  input  logic                  clk_g,
  input  logic                  rst_g,
  input  logic                  getir_istek_g,
  input  logic [ADRES_BIT-1:0]  getir_adres_g,
  input  logic                  getir_iptal_g,
  output logic                  getir_kabul_c,
  output logic [VERI_BIT-1:0]   getir_veri_c,
  output logic                  getir_veri_gecerli_c,
  input  logic                  yukle_istek_g,
  input  logic                  yukle_yaz_g,
  input  logic [ADRES_BIT-1:0]  yukle_adres_g,
  input  logic [VERI_BIT-1:0]   yukle_veri_g,
  input  logic [VERI_BIT/8-1:0] yukle_bayt_g,
  input  logic                  yukle_kilit_g,
  output logic                  yukle_kabul_c,
  output logic [VERI_BIT-1:0]   yukle_okunan_c,
  output logic                  yukle_okunan_gecerli_c,
  output logic                  bb_ena_c,
  output logic [VERI_BIT/8-1:0] bb_wea_c,
  output logic [ADRES_BIT-1:0]  bb_addra_c,
  output logic [VERI_BIT-1:0]   bb_dina_c,
  input  logic [VERI_BIT-1:0]   bb_douta_g
);
  localparam int SW = $clog2(ACLIK_SINIRI + 1);
  typedef enum logic [1:0] {
    BOSTA, GETIR, YUKLE
`ifdef YUKLE_KILIT_EN
    , KILIT
`endif
  } durum_t;
  durum_t durum_q, durum_d;
  logic [SW-1:0] aclik_q, aclik_d;
  logic yukle_kazan, getir_kazan, aclik_dolu, kilit_tut, kilit_oku;
`ifdef YUKLE_KILIT_EN
  logic oku_q;
  assign kilit_tut = durum_q == KILIT && yukle_kilit_g;
  assign kilit_oku = durum_q == KILIT && oku_q;
  always_ff @(posedge clk_g or posedge rst_g)
    if (rst_g) oku_q <= 1'b0;
    else oku_q <= yukle_kazan && !yukle_yaz_g;
`else
  logic unused_kilit;
  assign unused_kilit = yukle_kilit_g;
  assign kilit_tut = 1'b0;
  assign kilit_oku = 1'b0;
`endif
  assign aclik_dolu = aclik_q == SW'(ACLIK_SINIRI);
  always_comb begin
    yukle_kazan = yukle_istek_g && (kilit_tut || !getir_istek_g || aclik_dolu);
    getir_kazan = getir_istek_g && !yukle_kazan && !kilit_tut;
    aclik_d = (kilit_tut || !yukle_istek_g || yukle_kazan) ? '0 :
              aclik_dolu ? aclik_q : aclik_q + 1'b1;
    durum_d = yukle_kazan ? (yukle_yaz_g ? BOSTA : YUKLE) : getir_kazan ? GETIR : BOSTA;
`ifdef YUKLE_KILIT_EN
    if (kilit_tut || (yukle_kazan && yukle_kilit_g)) durum_d = KILIT;
`endif
  end
  always_ff @(posedge clk_g or posedge rst_g)
    if (rst_g) begin
      durum_q <= BOSTA;
      aclik_q <= '0;
    end else begin
      durum_q <= durum_d;
      aclik_q <= aclik_d;
    end
  assign getir_kabul_c          = getir_kazan;
  assign yukle_kabul_c          = yukle_kazan;
  assign bb_ena_c               = getir_kazan || yukle_kazan;
  assign bb_wea_c               = (yukle_kazan && yukle_yaz_g) ? yukle_bayt_g : '0;
  assign bb_addra_c             = yukle_kazan ? yukle_adres_g : getir_adres_g;
  assign bb_dina_c              = yukle_veri_g;
  assign getir_veri_c           = bb_douta_g;
  assign yukle_okunan_c         = bb_douta_g;
  assign getir_veri_gecerli_c   = durum_q == GETIR && !getir_iptal_g;
  assign yukle_okunan_gecerli_c = durum_q == YUKLE || kilit_oku;
endmodule

// File: tb/tb_bb_erisim_hakemi.sv
// tb_bb_erisim_hakemi: directed checks of arbitration, starvation guard, data return and reset.
module tb_bb_erisim_hakemi;
  logic        clk_g = 1'b0, rst_g = 1'b1;
  logic        getir_istek_g = 1'b0, getir_iptal_g = 1'b0, getir_kabul_c, getir_veri_gecerli_c;
  logic [31:0] getir_adres_g = '0, getir_veri_c;
  logic        yukle_istek_g = 1'b0, yukle_yaz_g = 1'b0, yukle_kilit_g = 1'b0;
  logic [31:0] yukle_adres_g = '0, yukle_veri_g = '0, yukle_okunan_c;
  logic [3:0]  yukle_bayt_g = '0;
  logic        yukle_kabul_c, yukle_okunan_gecerli_c, bb_ena_c;
  logic [3:0]  bb_wea_c;
  logic [31:0] bb_addra_c, bb_dina_c, bb_douta_g;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;

  bb_erisim_hakemi dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .getir_istek_g(getir_istek_g), .getir_adres_g(getir_adres_g), .getir_iptal_g(getir_iptal_g),
    .getir_kabul_c(getir_kabul_c), .getir_veri_c(getir_veri_c), .getir_veri_gecerli_c(getir_veri_gecerli_c),
    .yukle_istek_g(yukle_istek_g), .yukle_yaz_g(yukle_yaz_g), .yukle_adres_g(yukle_adres_g),
    .yukle_veri_g(yukle_veri_g), .yukle_bayt_g(yukle_bayt_g), .yukle_kilit_g(yukle_kilit_g),
    .yukle_kabul_c(yukle_kabul_c), .yukle_okunan_c(yukle_okunan_c), .yukle_okunan_gecerli_c(yukle_okunan_gecerli_c),
    .bb_ena_c(bb_ena_c), .bb_wea_c(bb_wea_c), .bb_addra_c(bb_addra_c), .bb_dina_c(bb_dina_c),
    .bb_douta_g(bb_douta_g)
  );

  always #5 clk_g = ~clk_g;

  // BRAM model: word i resets to 0xA0000000|i, read-first, 1-cycle latency
  always @(posedge clk_g) begin
    if (rst_g) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
    end else if (bb_ena_c) begin
      for (int b = 0; b < 4; b++)
        if (bb_wea_c[b]) mem[bb_addra_c[9:2]][8*b +: 8] <= bb_dina_c[8*b +: 8];
      bb_douta_g <= mem[bb_addra_c[9:2]];
    end
  end

  task automatic tick;
    @(posedge clk_g);
    #1;
  endtask

  task automatic idle;
    getir_istek_g = 1'b0; getir_iptal_g = 1'b0;
    yukle_istek_g = 1'b0; yukle_yaz_g = 1'b0; yukle_kilit_g = 1'b0; yukle_bayt_g = '0;
  endtask

  task automatic test_reset;
    tick; tick;
    checks++; if (getir_kabul_c !== 1'b0) begin errors++; $display("FAIL reset getir_kabul got %b want 0", getir_kabul_c); end
    checks++; if (yukle_kabul_c !== 1'b0) begin errors++; $display("FAIL reset yukle_kabul got %b want 0", yukle_kabul_c); end
    checks++; if (getir_veri_gecerli_c !== 1'b0 || yukle_okunan_gecerli_c !== 1'b0) begin errors++; $display("FAIL reset valids got %b%b want 00", getir_veri_gecerli_c, yukle_okunan_gecerli_c); end
    checks++; if (bb_ena_c !== 1'b0 || bb_wea_c !== 4'b0) begin errors++; $display("FAIL reset bb got ena=%b wea=%b want 0/0000", bb_ena_c, bb_wea_c); end
    rst_g = 1'b0;
  endtask

  task automatic test_fetch;
    tick;
    getir_istek_g = 1'b1; getir_adres_g = 32'h100; #1;
    checks++; if (getir_kabul_c !== 1'b1 || yukle_kabul_c !== 1'b0) begin errors++; $display("FAIL fetch kabul got %b%b want 10", getir_kabul_c, yukle_kabul_c); end
    checks++; if (bb_ena_c !== 1'b1 || bb_addra_c !== 32'h100 || bb_wea_c !== 4'b0) begin errors++; $display("FAIL fetch bb got ena=%b addr=%h wea=%b want 1/100/0000", bb_ena_c, bb_addra_c, bb_wea_c); end
    tick;
    getir_istek_g = 1'b0; #1;
    checks++; if (getir_veri_gecerli_c !== 1'b1 || yukle_okunan_gecerli_c !== 1'b0) begin errors++; $display("FAIL fetch valid got %b%b want 10", getir_veri_gecerli_c, yukle_okunan_gecerli_c); end
    checks++; if (getir_veri_c !== 32'hA000_0040) begin errors++; $display("FAIL fetch data got %h want a0000040", getir_veri_c); end
    tick;
    checks++; if (getir_veri_gecerli_c !== 1'b0) begin errors++; $display("FAIL fetch valid_drop got %b want 0", getir_veri_gecerli_c); end
  endtask

  task automatic test_write;
    yukle_istek_g = 1'b1; yukle_yaz_g = 1'b1; yukle_adres_g = 32'h20;
    yukle_veri_g = 32'hDEAD_BEEF; yukle_bayt_g = 4'b0011; #1;
    checks++; if (yukle_kabul_c !== 1'b1 || getir_kabul_c !== 1'b0) begin errors++; $display("FAIL write kabul got %b%b want 10", yukle_kabul_c, getir_kabul_c); end
    checks++; if (bb_wea_c !== 4'b0011 || bb_dina_c !== 32'hDEAD_BEEF || bb_addra_c !== 32'h20) begin errors++; $display("FAIL write bb got wea=%b din=%h addr=%h want 0011/deadbeef/20", bb_wea_c, bb_dina_c, bb_addra_c); end
    tick;
    yukle_yaz_g = 1'b0; yukle_bayt_g = 4'b1111; #1;
    checks++; if (yukle_okunan_gecerli_c !== 1'b0) begin errors++; $display("FAIL write no_valid got %b want 0", yukle_okunan_gecerli_c); end
    checks++; if (bb_wea_c !== 4'b0) begin errors++; $display("FAIL read wea got %b want 0000", bb_wea_c); end
    tick;
    idle; #1;
    checks++; if (yukle_okunan_gecerli_c !== 1'b1 || getir_veri_gecerli_c !== 1'b0) begin errors++; $display("FAIL readback valid got %b%b want 10", yukle_okunan_gecerli_c, getir_veri_gecerli_c); end
    checks++; if (yukle_okunan_c !== 32'hA000_BEEF) begin errors++; $display("FAIL readback data got %h want a000beef", yukle_okunan_c); end
    tick;
  endtask

  task automatic test_iptal;
    getir_istek_g = 1'b1; getir_adres_g = 32'h104; #1;
    checks++; if (getir_kabul_c !== 1'b1) begin errors++; $display("FAIL iptal first_kabul got %b want 1", getir_kabul_c); end
    tick;
    getir_adres_g = 32'h108; getir_iptal_g = 1'b1; #1;
    checks++; if (getir_kabul_c !== 1'b1) begin errors++; $display("FAIL iptal second_kabul got %b want 1", getir_kabul_c); end
    checks++; if (getir_veri_gecerli_c !== 1'b0) begin errors++; $display("FAIL iptal suppressed got %b want 0", getir_veri_gecerli_c); end
    tick;
    idle; #1;
    checks++; if (getir_veri_gecerli_c !== 1'b1 || getir_veri_c !== 32'hA000_0042) begin errors++; $display("FAIL iptal new_fetch got v=%b d=%h want 1/a0000042", getir_veri_gecerli_c, getir_veri_c); end
    tick;
  endtask

  task automatic test_starvation;
    logic eg, ey, pg, py;
    getir_istek_g = 1'b1; getir_adres_g = 32'h100;
    yukle_istek_g = 1'b1; yukle_yaz_g = 1'b0; yukle_adres_g = 32'h8;
    pg = 1'b0; py = 1'b0;
    for (int i = 0; i < 18; i++) begin
      #1;
      ey = (i % 9) == 8; eg = !ey;
      checks++; if (getir_kabul_c !== eg || yukle_kabul_c !== ey) begin errors++; $display("FAIL starve kabul cycle %0d got %b%b want %b%b", i, getir_kabul_c, yukle_kabul_c, eg, ey); end
      checks++; if (getir_veri_gecerli_c !== pg || yukle_okunan_gecerli_c !== py) begin errors++; $display("FAIL starve valid cycle %0d got %b%b want %b%b", i, getir_veri_gecerli_c, yukle_okunan_gecerli_c, pg, py); end
      pg = eg; py = ey;
      tick;
    end
    idle; #1;
    checks++; if (yukle_okunan_gecerli_c !== 1'b1 || yukle_okunan_c !== 32'hA000_0002) begin errors++; $display("FAIL starve last_read got v=%b d=%h want 1/a0000002", yukle_okunan_gecerli_c, yukle_okunan_c); end
    tick;
  endtask

  task automatic test_aclik_clear;
    logic ey;
    getir_istek_g = 1'b1; getir_adres_g = 32'h100; yukle_adres_g = 32'h8;
    for (int i = 0; i < 15; i++) begin
      yukle_istek_g = i != 5; #1;
      ey = i == 14;
      checks++; if (yukle_kabul_c !== ey || getir_kabul_c !== !ey) begin errors++; $display("FAIL aclik_clear cycle %0d got g=%b y=%b want g=%b y=%b", i, getir_kabul_c, yukle_kabul_c, !ey, ey); end
      tick;
    end
    idle; tick;
  endtask

  task automatic test_async_reset;
    getir_istek_g = 1'b1; getir_adres_g = 32'h100; #1;
    checks++; if (getir_kabul_c !== 1'b1) begin errors++; $display("FAIL areset kabul got %b want 1", getir_kabul_c); end
    tick;
    getir_istek_g = 1'b0; #1;
    checks++; if (getir_veri_gecerli_c !== 1'b1) begin errors++; $display("FAIL areset pre_valid got %b want 1", getir_veri_gecerli_c); end
    #1 rst_g = 1'b1; #1;
    checks++; if (getir_veri_gecerli_c !== 1'b0 || yukle_okunan_gecerli_c !== 1'b0) begin errors++; $display("FAIL areset immediate got %b%b want 00", getir_veri_gecerli_c, yukle_okunan_gecerli_c); end
    tick; tick;
    #2 rst_g = 1'b0;
    tick;
    checks++; if (getir_veri_gecerli_c !== 1'b0 || yukle_okunan_gecerli_c !== 1'b0) begin errors++; $display("FAIL areset stale got %b%b want 00", getir_veri_gecerli_c, yukle_okunan_gecerli_c); end
    getir_istek_g = 1'b1; getir_adres_g = 32'h104; #1;
    checks++; if (getir_kabul_c !== 1'b1) begin errors++; $display("FAIL areset resume_kabul got %b want 1", getir_kabul_c); end
    tick;
    idle; #1;
    checks++; if (getir_veri_gecerli_c !== 1'b1 || getir_veri_c !== 32'hA000_0041) begin errors++; $display("FAIL areset resume got v=%b d=%h want 1/a0000041", getir_veri_gecerli_c, getir_veri_c); end
    tick;
  endtask

`ifdef YUKLE_KILIT_EN
  task automatic test_lock;
    yukle_istek_g = 1'b1; yukle_yaz_g = 1'b1; yukle_kilit_g = 1'b1;
    yukle_adres_g = 32'h30; yukle_bayt_g = 4'b0; #1;
    checks++; if (yukle_kabul_c !== 1'b1) begin errors++; $display("FAIL lock enter got %b want 1", yukle_kabul_c); end
    tick;
    yukle_yaz_g = 1'b0; yukle_adres_g = 32'h8;
    getir_istek_g = 1'b1; getir_adres_g = 32'h100;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (getir_kabul_c !== 1'b0 || yukle_kabul_c !== 1'b1) begin errors++; $display("FAIL lock hold cycle %0d got g=%b y=%b want 0/1", i, getir_kabul_c, yukle_kabul_c); end
      checks++; if (yukle_okunan_gecerli_c !== (i > 0)) begin errors++; $display("FAIL lock read_valid cycle %0d got %b want %b", i, yukle_okunan_gecerli_c, i > 0); end
      tick;
    end
    yukle_kilit_g = 1'b0; #1;
    checks++; if (getir_kabul_c !== 1'b1 || yukle_kabul_c !== 1'b0) begin errors++; $display("FAIL lock release got g=%b y=%b want 1/0", getir_kabul_c, yukle_kabul_c); end
    checks++; if (yukle_okunan_gecerli_c !== 1'b1 || yukle_okunan_c !== 32'hA000_0002) begin errors++; $display("FAIL lock last_read got v=%b d=%h want 1/a0000002", yukle_okunan_gecerli_c, yukle_okunan_c); end
    idle; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_fetch;
    test_write;
    test_iptal;
    test_starvation;
    test_aclik_clear;
`ifdef YUKLE_KILIT_EN
    test_lock;
`endif
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
